// File: rtl/mips_avalon_master.sv
// rtl/mips_avalon_master.sv - single-outstanding Avalon-MM master for the MIPS core bus port
module mips_avalon_master #(
    parameter int unsigned TIMEOUT      = 0,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteenable,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        timeout,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_next;
    logic        accept;
    logic        reject;
    logic [31:0] wait_cnt;
    logic [31:0] wait_inc;

    assign accept   = (state == IDLE) && req_valid;
    assign reject   = (req_addr[1:0] != 2'b00) || (req_write && (req_byteenable == 4'b0000));
    assign wait_inc = (wait_cnt == 32'hFFFF_FFFF) ? wait_cnt : wait_cnt + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = reject ? RESP : BUS;
            end
            BUS: begin
                if (!waitrequest) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs only change at acceptance or completion, so they stay frozen while waitrequest is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address    <= RESET_VECTOR;
            writedata  <= 32'd0;
            byteenable <= 4'b0000;
            read       <= 1'b0;
            write      <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            timeout    <= 1'b0;
            wait_cnt   <= 32'd0;
        end else if (accept) begin
            if (reject) begin
                resp_err   <= 1'b1;
                resp_rdata <= 32'd0;
            end else begin
                address    <= req_addr;
                writedata  <= req_wdata;
                byteenable <= req_write ? req_byteenable : 4'b1111;
                read       <= !req_write;
                write      <= req_write;
                resp_err   <= 1'b0;
                wait_cnt   <= 32'd0;
            end
        end else if (state == BUS) begin
            if (waitrequest) begin
                wait_cnt <= wait_inc;
                // Flag only; the transfer cannot be abandoned while the slave stalls.
                if ((TIMEOUT != 0) && (wait_inc >= TIMEOUT)) timeout <= 1'b1;
            end else begin
                read  <= 1'b0;
                write <= 1'b0;
                if (read) resp_rdata <= readdata;
            end
        end
    end

endmodule
